// File: rtl/bus_pkg.sv
// Shared gate encodings, arbiter state type and index-to-gate helper for the bus mux arbiter.
// Pure definitions: no logic, no latency, no flow control.
package bus_pkg;

    localparam logic [3:0] GATE_D0   = 4'b1000;
    localparam logic [3:0] GATE_D1   = 4'b0100;
    localparam logic [3:0] GATE_D2   = 4'b0010;
    localparam logic [3:0] GATE_D3   = 4'b0001;
    localparam logic [3:0] GATE_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } arb_state_t;

    function automatic logic [3:0] idx2gate(input logic [1:0] idx);
        logic [3:0] g;
        case (idx)
            2'd0:    g = GATE_D0;
            2'd1:    g = GATE_D1;
            2'd2:    g = GATE_D2;
            default: g = GATE_D3;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bus_gate_arbiter_rr_pick.sv
// Round-robin winner search over four requests, starting at last+1 and ending at last.
// Purely combinational (zero latency); req[3] is source 0.
module rr_pick
    import bus_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       any_req
);

    logic [1:0] cand;

    // Walk from lowest priority (last itself) up to last+1 so the highest-priority hit overwrites.
    always_comb begin
        winner = last;
        cand   = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + k[1:0];
            if (req[2'd3 - cand]) begin
                winner = cand;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/bus_gate_arbiter.sv
// Bus owner arbiter: one-hot registered gate, 1-cycle request-to-gate, one idle cycle between owners.
// Ownership held until req[owner] drops; BUS_ARB_PREEMPT_EN adds a hold limit that forces a turn.
module bus_gate_arbiter
    import bus_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] req,
    output logic [3:0] gate,
    output logic [1:0] owner,
    output logic       busy,
    output logic       preempted
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255 || (HOLD_MAX - 1) >= (1 << CNT_W)) begin : g_bad_cfg
        $error("bus_gate_arbiter: HOLD_MAX out of range for CNT_W");
    end

    arb_state_t state_q, state_d;
    logic [3:0] gate_q, gate_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [1:0] winner;
    logic       any_req;
    logic       rel_own;

    rr_pick u_rr_pick (
        .req     (req),
        .last    (last_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign rel_own = ~req[2'd3 - owner_q];

`ifdef BUS_ARB_PREEMPT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             pre_q, pre_d;
    logic             other_req;

    assign other_req = |(req & ~idx2gate(owner_q));
`endif

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        owner_d = owner_q;
        last_d  = last_q;
`ifdef BUS_ARB_PREEMPT_EN
        hold_d  = hold_q;
        pre_d   = 1'b0;
`endif
        case (state_q)
            GRANT: begin
                if (rel_own) begin
                    state_d = TURN;
                    gate_d  = GATE_NONE;
`ifdef BUS_ARB_PREEMPT_EN
                end else if (hold_q == HOLD_LAST && other_req) begin
                    state_d = TURN;
                    gate_d  = GATE_NONE;
                    last_d  = owner_q;
                    pre_d   = 1'b1;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d  = hold_q + 1'b1;
`endif
                end
            end
            // IDLE and TURN pick identically; TURN differs only in being entered from GRANT.
            default: begin
                if (any_req) begin
                    state_d = GRANT;
                    owner_d = winner;
                    last_d  = winner;
                    gate_d  = idx2gate(winner);
`ifdef BUS_ARB_PREEMPT_EN
                    hold_d  = '0;
`endif
                end else begin
                    state_d = IDLE;
                    gate_d  = GATE_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            gate_q  <= GATE_NONE;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

`ifdef BUS_ARB_PREEMPT_EN
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            hold_q <= '0;
            pre_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            pre_q  <= pre_d;
        end
    end

    assign preempted = pre_q;
`else
    assign preempted = 1'b0;
`endif

    assign gate  = gate_q;
    assign owner = owner_q;
    assign busy  = |gate_q;

endmodule
